// File: rtl/spi_baud_generator_pkg.sv
// Shared definitions for the SPI baud-rate generator: mode encodings,
// the divisor width and the divisor calculation.
package spi_baud_generator_pkg;

  localparam int DIV_W = 12;

  typedef enum logic [1:0] {
    MODE_RUN  = 2'b00,
    MODE_WAIT = 2'b01,
    MODE_STOP = 2'b10
  } spimode_e;

  // (sppr + 1) * 2^(spr + 1); the largest value is 8 << 8 = 2048.
  function automatic logic [DIV_W-1:0] calc_divisor(input logic [2:0] sppr,
                                                    input logic [2:0] spr);
    logic [DIV_W-1:0] base;
    logic [3:0]       shamt;
    base  = {{(DIV_W-3){1'b0}}, sppr} + {{(DIV_W-1){1'b0}}, 1'b1};
    shamt = {1'b0, spr} + 4'd1;
    return base << shamt;
  endfunction

endpackage

// File: rtl/spi_baud_generator_if.sv
// Bundle between the SPI control registers / shifter and the baud generator.
// master: register and shifter side; slave: the generator itself.
interface spi_baud_generator_if;
  import spi_baud_generator_pkg::*;

  logic [1:0]       spimode;
  logic             spiswai;
  logic [2:0]       sppr;
  logic [2:0]       spr;
  logic             cpol;
  logic             cpha;
  logic             ss;
  logic             sclk;
  logic             flaglow;
  logic             flaghigh;
  logic             flagslow;
  logic             flagshigh;
  logic [DIV_W-1:0] baudratedivisor;

  modport master (
    output spimode, spiswai, sppr, spr, cpol, cpha, ss,
    input  sclk, flaglow, flaghigh, flagslow, flagshigh, baudratedivisor
  );

  modport slave (
    input  spimode, spiswai, sppr, spr, cpol, cpha, ss,
    output sclk, flaglow, flaghigh, flagslow, flagshigh, baudratedivisor
  );

endinterface

// File: rtl/spi_baud_generator.sv
// SPI master serial-clock generator. Divides pclk by the programmed baud
// divisor, drives sclk at the configured polarity and emits one-cycle
// receive/transmit strobes aligned to the sclk edges.
module spi_baud_generator
  import spi_baud_generator_pkg::*;
(
  input  logic                 pclk,
  input  logic                 presetn,
  spi_baud_generator_if.slave  bus
);

  localparam logic [DIV_W-1:0] ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [DIV_W-1:0] TWO  = {{(DIV_W-2){1'b0}}, 2'b10};

  logic [DIV_W-1:0] divisor_s;
  logic [DIV_W-1:0] half_s;
  logic [DIV_W-1:0] half_m1_s;
  logic [DIV_W-1:0] half_m2_s;
  logic             active_s;
  logic             same_phase_s;
  logic             gate_lvl_s;
  logic             rx_hit_s;
  logic             tx_hit_s;

  logic [DIV_W-1:0] count_q, count_d;
  logic             sclk_q, sclk_d;
  logic             flaglow_q, flaglow_d;
  logic             flaghigh_q, flaghigh_d;
  logic             flagslow_q, flagslow_d;
  logic             flagshigh_q, flagshigh_d;

  // Divisor, half period and run qualification decoded from the live controls.
  always_comb begin
    divisor_s    = calc_divisor(bus.sppr, bus.spr);
    half_s       = divisor_s >> 1;
    half_m1_s    = half_s - ONE;
    half_m2_s    = half_s - TWO;
    same_phase_s = (bus.cpol == bus.cpha);
    // Strobes are gated to the sclk level preceding the sampling edge.
    gate_lvl_s   = ~same_phase_s;
    active_s     = ~bus.ss &&
                   ((bus.spimode == MODE_RUN) ||
                    ((bus.spimode == MODE_WAIT) && ~bus.spiswai));
  end

  // Next-state: counter, sclk, and strobes looked ahead from the next count so
  // the registered flag lines up with the cycle it describes.
  always_comb begin
    count_d     = ZERO;
    sclk_d      = bus.cpol;
    rx_hit_s    = 1'b0;
    tx_hit_s    = 1'b0;
    flaglow_d   = 1'b0;
    flaghigh_d  = 1'b0;
    flagslow_d  = 1'b0;
    flagshigh_d = 1'b0;
    if (active_s) begin
      // >= so that shrinking the divisor mid-run toggles on the next cycle.
      if (count_q >= half_m1_s) begin
        count_d = ZERO;
        sclk_d  = ~sclk_q;
      end else begin
        count_d = count_q + ONE;
        sclk_d  = sclk_q;
      end
      rx_hit_s = (count_d == half_m1_s) && (sclk_d == gate_lvl_s);
      if (half_s == ONE) begin
        // Divide-by-2: sclk flips every cycle, so the transmit slot is the
        // preceding cycle at the opposite level.
        tx_hit_s = (sclk_d != gate_lvl_s);
      end else begin
        tx_hit_s = (count_d == half_m2_s) && (sclk_d == gate_lvl_s);
      end
      flaglow_d   = rx_hit_s &&  same_phase_s;
      flaghigh_d  = rx_hit_s && ~same_phase_s;
      flagslow_d  = tx_hit_s &&  same_phase_s;
      flagshigh_d = tx_hit_s && ~same_phase_s;
    end else begin
      count_d = ZERO;
      sclk_d  = bus.cpol;
    end
  end

  // State registers with synchronous reset to the idle clock level.
  always_ff @(posedge pclk) begin
    if (presetn) begin
      count_q     <= ZERO;
      sclk_q      <= bus.cpol;
      flaglow_q   <= 1'b0;
      flaghigh_q  <= 1'b0;
      flagslow_q  <= 1'b0;
      flagshigh_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      sclk_q      <= sclk_d;
      flaglow_q   <= flaglow_d;
      flaghigh_q  <= flaghigh_d;
      flagslow_q  <= flagslow_d;
      flagshigh_q <= flagshigh_d;
    end
  end

  assign bus.sclk            = sclk_q;
  assign bus.flaglow         = flaglow_q;
  assign bus.flaghigh        = flaghigh_q;
  assign bus.flagslow        = flagslow_q;
  assign bus.flagshigh       = flagshigh_q;
  assign bus.baudratedivisor = divisor_s;

endmodule

// File: tb/tb_spi_baud_generator.sv
// Directed bench for spi_baud_generator with hand-computed expectations.
module tb_spi_baud_generator;
  import spi_baud_generator_pkg::*;

  logic pclk;
  logic presetn;
  int   checks;
  int   errors;

  // Expected per-edge patterns for divisor 8 (half 4) starting from count 0,
  // bit k-1 is the value after the k-th active edge.
  logic [11:0] exp_sclk_v;
  logic [11:0] exp_flaglow_v;
  logic [11:0] exp_flagslow_v;
  logic [11:0] exp_flaghigh_v;
  logic [11:0] exp_flagshigh_v;

  spi_baud_generator_if bus_if ();

  spi_baud_generator dut (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (bus_if)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Flags packed as {flaglow, flaghigh, flagslow, flagshigh}.
  task automatic check_flags(input string tag, input logic [3:0] exp);
    check(tag, {8'd0, bus_if.flaglow, bus_if.flaghigh, bus_if.flagslow, bus_if.flagshigh},
          {8'd0, exp});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_sclk_v      = 12'b1000_0111_1000;
    exp_flagslow_v  = 12'b0010_0000_0010;
    exp_flaglow_v   = 12'b0100_0000_0100;
    exp_flagshigh_v = 12'b0000_0010_0000;
    exp_flaghigh_v  = 12'b0000_0100_0000;

    // Reset with cpol=1.
    presetn         = 1'b1;
    bus_if.spimode  = 2'b00;
    bus_if.spiswai  = 1'b0;
    bus_if.sppr     = 3'd0;
    bus_if.spr      = 3'd0;
    bus_if.cpol     = 1'b1;
    bus_if.cpha     = 1'b1;
    bus_if.ss       = 1'b1;
    repeat (3) tick();
    check("reset_sclk", {11'd0, bus_if.sclk}, 12'd1);
    check_flags("reset_flags", 4'b0000);
    check("div_2", bus_if.baudratedivisor, 12'd2);
    presetn = 1'b0;
    repeat (2) tick();
    check("idle_ss_sclk", {11'd0, bus_if.sclk}, 12'd1);
    check_flags("idle_ss_flags", 4'b0000);

    // Divide-by-2, cpol=cpha=0.
    bus_if.cpol = 1'b0;
    bus_if.cpha = 1'b0;
    tick();
    check("idle_cpol0_sclk", {11'd0, bus_if.sclk}, 12'd0);
    bus_if.ss = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("div2_sclk", {11'd0, bus_if.sclk}, (k % 2 == 0) ? 12'd1 : 12'd0);
      check_flags("div2_flags", (k % 2 == 0) ? 4'b0010 : 4'b1000);
    end

    // Divisor 8, cpol=cpha=0: low-phase strobes only.
    bus_if.ss   = 1'b1;
    bus_if.sppr = 3'd1;
    bus_if.spr  = 3'd1;
    tick();
    check("div8_idle_sclk", {11'd0, bus_if.sclk}, 12'd0);
    check_flags("div8_idle_flags", 4'b0000);
    check("div_8", bus_if.baudratedivisor, 12'd8);
    bus_if.ss = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check("div8_sclk", {11'd0, bus_if.sclk}, {11'd0, exp_sclk_v[k-1]});
      check_flags("div8_low_flags", {exp_flaglow_v[k-1], 1'b0, exp_flagslow_v[k-1], 1'b0});
    end

    // Divisor 8, cpol=0 cpha=1: high-phase strobes only.
    bus_if.ss   = 1'b1;
    bus_if.cpha = 1'b1;
    tick();
    check("cpha1_idle_sclk", {11'd0, bus_if.sclk}, 12'd0);
    bus_if.ss = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check("cpha1_sclk", {11'd0, bus_if.sclk}, {11'd0, exp_sclk_v[k-1]});
      check_flags("cpha1_high_flags", {1'b0, exp_flaghigh_v[k-1], 1'b0, exp_flagshigh_v[k-1]});
    end

    // Divisor corner values.
    bus_if.sppr = 3'd7;
    bus_if.spr  = 3'd7;
    #1;
    check("div_2048", bus_if.baudratedivisor, 12'd2048);
    bus_if.sppr = 3'd2;
    bus_if.spr  = 3'd3;
    #1;
    check("div_48", bus_if.baudratedivisor, 12'd48);
    bus_if.sppr = 3'd1;
    bus_if.spr  = 3'd0;
    #1;
    check("div_4", bus_if.baudratedivisor, 12'd4);

    // Wait mode with stop-in-wait, then resume; stop modes.
    bus_if.ss   = 1'b1;
    bus_if.cpha = 1'b0;
    bus_if.sppr = 3'd1;
    bus_if.spr  = 3'd1;
    tick();
    bus_if.ss = 1'b0;
    repeat (5) tick();
    check("pre_wait_sclk", {11'd0, bus_if.sclk}, 12'd1);
    bus_if.spimode = 2'b01;
    bus_if.spiswai = 1'b1;
    tick();
    check("wait_sclk", {11'd0, bus_if.sclk}, 12'd0);
    check_flags("wait_flags", 4'b0000);
    repeat (2) tick();
    check("wait_hold_sclk", {11'd0, bus_if.sclk}, 12'd0);
    check_flags("wait_hold_flags", 4'b0000);
    bus_if.spiswai = 1'b0;
    repeat (3) tick();
    check("resume_sclk", {11'd0, bus_if.sclk}, 12'd0);
    check_flags("resume_flaglow", 4'b1000);
    tick();
    check("resume_edge", {11'd0, bus_if.sclk}, 12'd1);
    bus_if.spimode = 2'b10;
    tick();
    check("stop10_sclk", {11'd0, bus_if.sclk}, 12'd0);
    check_flags("stop10_flags", 4'b0000);
    bus_if.spimode = 2'b11;
    tick();
    check("stop11_sclk", {11'd0, bus_if.sclk}, 12'd0);
    bus_if.spimode = 2'b00;

    // Shrinking the divisor mid-run: count above new half-1 toggles next cycle.
    bus_if.ss = 1'b1;
    tick();
    bus_if.ss = 1'b0;
    repeat (2) tick();
    check_flags("pre_shrink_flags", 4'b0010);
    bus_if.sppr = 3'd0;
    bus_if.spr  = 3'd0;
    tick();
    check("shrink_sclk", {11'd0, bus_if.sclk}, 12'd1);
    check_flags("shrink_flags", 4'b0010);

    // ss raised mid-period, then reset mid-run, cpol=1 cpha=0.
    bus_if.ss   = 1'b1;
    bus_if.cpol = 1'b1;
    bus_if.sppr = 3'd1;
    bus_if.spr  = 3'd1;
    tick();
    check("cpol1_idle_sclk", {11'd0, bus_if.sclk}, 12'd1);
    check_flags("cpol1_idle_flags", 4'b0000);
    bus_if.ss = 1'b0;
    repeat (3) tick();
    check("cpol1_run_sclk", {11'd0, bus_if.sclk}, 12'd1);
    check_flags("cpol1_flaghigh", 4'b0100);
    repeat (2) tick();
    check("cpol1_low_sclk", {11'd0, bus_if.sclk}, 12'd0);
    bus_if.ss = 1'b1;
    tick();
    check("ss_drop_sclk", {11'd0, bus_if.sclk}, 12'd1);
    check_flags("ss_drop_flags", 4'b0000);
    tick();
    check_flags("ss_hold_flags", 4'b0000);
    bus_if.ss = 1'b0;
    repeat (5) tick();
    check("prereset_sclk", {11'd0, bus_if.sclk}, 12'd0);
    presetn = 1'b1;
    tick();
    check("midreset_sclk", {11'd0, bus_if.sclk}, 12'd1);
    check_flags("midreset_flags", 4'b0000);
    presetn = 1'b0;
    repeat (3) tick();
    check("postreset_sclk", {11'd0, bus_if.sclk}, 12'd1);
    check_flags("postreset_flaghigh", 4'b0100);
    tick();
    check("postreset_edge", {11'd0, bus_if.sclk}, 12'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
